uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine_if.sv | 23 ++
 rtl/uart_tx_engine.sv | 130 +++++++++++++
 tb/tb_uart_tx_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - parallel-in / serial-out bundle for the UART transmit engine
interface uart_tx_engine_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      busy;

    modport master (
        output P_DATA, Data_valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART frame serialiser: start, LSB-first data, optional parity, stop
module uart_tx_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                CLK,
    input  logic                RST,
    uart_tx_engine_if.slave     bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [2:0]                state;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] cyc_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic                      tx_q;
    logic                      busy_q;

    logic [PRESCALE_WIDTH-1:0] cyc_last;
    logic                      bit_wrap;
    logic                      parity_bit;
    logic [IDX_W-1:0]          next_idx;

    // Prescale of 0 and 1 both mean one clock per bit, so the wrap point is 0 for both.
    always_comb begin
        cyc_last   = (prescale_q <= PRESCALE_WIDTH'(1)) ? '0 : prescale_q - PRESCALE_WIDTH'(1);
        bit_wrap   = (cyc_cnt == cyc_last);
        parity_bit = (^data_q) ^ par_typ_q;
        next_idx   = bit_idx + IDX_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
            cyc_cnt    <= '0;
            bit_idx    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            if (state != IDLE) begin
                cyc_cnt <= bit_wrap ? '0 : cyc_cnt + PRESCALE_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    // The start bit goes out on the accepting edge itself.
                    if (bus.Data_valid) begin
                        data_q     <= bus.P_DATA;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        prescale_q <= bus.Prescale;
                        state      <= START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                START: begin
                    if (bit_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_q    <= data_q[0];
                    end
                end

                DATA: begin
                    if (bit_wrap) begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (par_en_q) begin
                                state <= PARITY;
                                tx_q  <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= next_idx;
                            tx_q    <= data_q[next_idx];
                        end
                    end
                end

                PARITY: begin
                    if (bit_wrap) begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                    end
                end

                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_wrap) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine against a per-cycle frame model
module tb_uart_tx_engine;
    logic TX_CLK_TB;
    logic RST;

    uart_tx_engine_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) bus ();

    uart_tx_engine #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
        .CLK (TX_CLK_TB),
        .RST (RST),
        .bus (bus)
    );

    initial TX_CLK_TB = 1'b0;
    always #5 TX_CLK_TB = ~TX_CLK_TB;

    int   vectors    = 0;
    int   miscompares = 0;
    logic exp_bits[$];
    int   exp_len[$];
    int   exp_gap[$];
    logic cap[$];
    bit   capturing = 0;
    bit   mon_en    = 0;
    int   idle_cnt  = 1000;
    int   cap_gap   = 0;

    // Expected line level for every clock of a frame; trunc >= 0 keeps only the first trunc clocks.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [4:0] ps, input int gap, input int trunc);
        int   p;
        int   n;
        logic b[$];
        p = (ps < 5'd2) ? 1 : int'(ps);
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (pe) b.push_back((^d) ^ pt);
        b.push_back(1'b1);
        n = 0;
        foreach (b[i]) begin
            for (int k = 0; k < p; k++) begin
                if (trunc < 0 || n < trunc) begin
                    exp_bits.push_back(b[i]);
                    n++;
                end
            end
        end
        exp_len.push_back(n);
        exp_gap.push_back(gap);
    endtask

    task automatic check_frame();
        int   len;
        int   gap;
        int   bad;
        logic e;
        logic bad_exp;
        vectors++;
        if (exp_len.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_frame: got frame of %0d busy cycles, required none", cap.size());
            return;
        end
        len = exp_len.pop_front();
        gap = exp_gap.pop_front();
        if (cap.size() != len) begin
            miscompares++;
            $display("FAIL busy_length: got %0d cycles, required %0d", cap.size(), len);
        end
        bad = -1;
        bad_exp = 1'b0;
        for (int i = 0; i < len; i++) begin
            e = exp_bits.pop_front();
            if (bad < 0 && (i >= cap.size() || cap[i] !== e)) begin
                bad = i;
                bad_exp = e;
            end
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL frame_bits: cycle %0d got %b, required %b", bad,
                     (bad < cap.size()) ? cap[bad] : 1'bx, bad_exp);
        end
        if (gap >= 0) begin
            vectors++;
            if (cap_gap != gap) begin
                miscompares++;
                $display("FAIL frame_gap: got %0d idle cycles, required %0d", cap_gap, gap);
            end
        end
    endtask

    always @(negedge TX_CLK_TB) begin
        if (mon_en) begin
            if (bus.busy === 1'b1) begin
                if (!capturing) begin
                    capturing = 1;
                    cap_gap = idle_cnt;
                    cap.delete();
                end
                cap.push_back(bus.TX_OUT);
            end else begin
                if (capturing) begin
                    capturing = 0;
                    check_frame();
                    idle_cnt = 0;
                end
                idle_cnt++;
                vectors++;
                if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_line: got TX_OUT=%b busy=%b, required 1 0", bus.TX_OUT, bus.busy);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge TX_CLK_TB);
        while (bus.busy !== 1'b0 && n < 1000) begin
            @(negedge TX_CLK_TB);
            n++;
        end
        if (n >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    // Inputs are scrambled and Data_valid pulsed while the frame is in flight.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [4:0] ps, input int gap, input int abort_at);
        int cyc;
        wait_idle();
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.Prescale = ps;
        bus.Data_valid = 1'b1;
        push_frame(d, pe, pt, ps, gap, (abort_at < 0) ? -1 : abort_at + 1);
        @(posedge TX_CLK_TB);
        cyc = 0;
        forever begin
            @(negedge TX_CLK_TB);
            if (abort_at >= 0 && cyc == abort_at) begin
                RST = 1'b1;
                bus.Data_valid = 1'b0;
                @(negedge TX_CLK_TB);
                RST = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1 || cyc > 2000) begin
                bus.Data_valid = 1'b0;
                break;
            end
            bus.P_DATA = 8'($urandom);
            bus.PAR_EN = 1'($urandom);
            bus.PAR_TYP = 1'($urandom);
            bus.Prescale = 5'($urandom);
            bus.Data_valid = ($urandom_range(0, 3) == 0);
            cyc++;
        end
    endtask

    initial begin
        int n;
        RST = 1'b1;
        bus.P_DATA = '0;
        bus.Data_valid = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.Prescale = '0;
        repeat (3) @(negedge TX_CLK_TB);
        vectors++;
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got TX_OUT=%b busy=%b, required 1 0", bus.TX_OUT, bus.busy);
        end
        RST = 1'b0;
        mon_en = 1;

        send(8'hA5, 1'b1, 1'b0, 5'd8, -1, -1);
        send(8'h07, 1'b1, 1'b0, 5'd8, -1, -1);
        send(8'h07, 1'b1, 1'b1, 5'd8, -1, -1);
        send(8'h3C, 1'b0, 1'b0, 5'd1, -1, -1);
        send(8'hC3, 1'b1, 1'b1, 5'd0, -1, -1);
        send(8'h81, 1'b0, 1'b0, 5'd31, -1, -1);

        // Data_valid held across two frames: exactly one idle cycle between them.
        wait_idle();
        bus.P_DATA = 8'h55;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.Prescale = 5'd3;
        bus.Data_valid = 1'b1;
        push_frame(8'h55, 1'b1, 1'b0, 5'd3, -1, -1);
        push_frame(8'hAA, 1'b1, 1'b0, 5'd3, 1, -1);
        @(posedge TX_CLK_TB);
        @(negedge TX_CLK_TB);
        bus.P_DATA = 8'hAA;
        n = 0;
        while (bus.busy === 1'b1 && n < 500) begin
            @(negedge TX_CLK_TB);
            n++;
        end
        @(negedge TX_CLK_TB);
        bus.Data_valid = 1'b0;

        // Reset during DATA bit 3 (cycles 16..19 at P=4).
        send(8'h5A, 1'b1, 1'b0, 5'd4, -1, 17);
        send(8'hA5, 1'b1, 1'b0, 5'd8, -1, -1);

        wait_idle();
        RST = 1'b1;
        bus.Data_valid = 1'b1;
        bus.P_DATA = 8'hFF;
        @(negedge TX_CLK_TB);
        RST = 1'b0;
        bus.Data_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_priority: got busy=%b TX_OUT=%b, required 0 1", bus.busy, bus.TX_OUT);
        end

        repeat (25) send(8'($urandom), 1'($urandom), 1'($urandom),
                         5'($urandom_range(0, 20)), -1, -1);

        n = 0;
        while ((capturing || exp_len.size() != 0) && n < 1000) begin
            @(negedge TX_CLK_TB);
            n++;
        end
        repeat (3) @(negedge TX_CLK_TB);
        vectors++;
        if (exp_len.size() != 0 || capturing) begin
            miscompares++;
            $display("FAIL drain: got %0d frames outstanding, required 0", exp_len.size());
        end
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
